lu_icode_issuer: RTL

- Upstream issue stage for the LU increment pipeline. Drives its 8-bit ICODE input every cycle.
- Buffers address codes from a producer through a valid/ready handshake in a small FIFO, and emits exactly one code per clock.
- The LU pipeline consumes a code on every cycle, so when there is no real work the block emits a reserved sink address, IDLE_CODE.
- After a stop request, a drain/flush sequence lets all in-flight increments retire before done is signalled.

---
 rtl/lu_pkg.sv | 16 +
 rtl/lu_icode_issuer_if.sv | 11 +
 rtl/lu_code_fifo.sv | 58 +++++
 rtl/lu_icode_issuer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/lu_pkg.sv
// Shared definitions for the LU increment pipeline: address/data widths,
// the default sink code, the pipeline depth and the issuer state encoding.
package lu_pkg;

    localparam int LU_ADDR_W = 8;
    localparam int LU_DATA_W = 16;
    localparam logic [LU_ADDR_W-1:0] LU_IDLE_CODE_DEF = 8'hFF;
    localparam int LU_PIPE_DEPTH = 5;

    typedef enum logic [1:0] {
        ISS_IDLE  = 2'd0,
        ISS_RUN   = 2'd1,
        ISS_DRAIN = 2'd2
    } iss_state_e;

endpackage

// File: rtl/lu_icode_issuer_if.sv
// Producer-side valid/ready handshake carrying one LU address code per transfer.
interface lu_icode_issuer_if import lu_pkg::*; ();

    logic                 in_valid;
    logic [LU_ADDR_W-1:0] in_code;
    logic                 in_ready;

    modport master (output in_valid, output in_code, input in_ready);
    modport slave  (input in_valid, input in_code, output in_ready);

endinterface

// File: rtl/lu_code_fifo.sv
// Synchronous FIFO with a combinational head; DEPTH must be a power of two
// so the pointers wrap by natural overflow.
module lu_code_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          push_s;
    logic          pop_s;

    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign full   = (level_r == (AW+1)'(DEPTH));
    assign empty  = (level_r == (AW+1)'(0));
    assign level  = level_r;
    assign dout   = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= (AW+1)'(0);
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/lu_icode_issuer.sv
// Issue stage feeding one code per clock to the LU ICODE input, with drain/flush.
// Optional macro LU_ISSUE_DROP_IDLE_EN: discard incoming IDLE_CODE values and count them on drop_cnt.
module lu_icode_issuer import lu_pkg::*; #(
    parameter int                   DEPTH        = 8,
    parameter logic [LU_ADDR_W-1:0] IDLE_CODE    = LU_IDLE_CODE_DEF,
    parameter int                   FLUSH_CYCLES = LU_PIPE_DEPTH,
    parameter int                   CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    lu_icode_issuer_if.slave       in_bus,
    input  logic                   start,
    input  logic                   stop,
    output logic [LU_ADDR_W-1:0]   icode,
    output logic                   icode_live,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       issued_cnt
`ifdef LU_ISSUE_DROP_IDLE_EN
    ,
    output logic [7:0]             drop_cnt
`endif
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    iss_state_e           state_r;
    iss_state_e           state_s;
    logic [FW-1:0]        flush_cnt_r;
    logic [FW-1:0]        flush_cnt_s;
    logic                 done_s;
    logic                 done_r;
    logic [LU_ADDR_W-1:0] icode_r;
    logic                 icode_live_r;
    logic [CNT_W-1:0]     issued_cnt_r;
    logic                 ready_s;
    logic                 push_s;
    logic                 store_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 empty_s;
    logic [LU_ADDR_W-1:0] head_s;

    // A full FIFO refuses input even when it pops in the same cycle.
    assign ready_s         = !full_s && (state_r != ISS_DRAIN);
    assign in_bus.in_ready = ready_s;
    assign push_s          = in_bus.in_valid && ready_s;
    assign pop_s           = (state_r != ISS_IDLE) && !empty_s;

`ifdef LU_ISSUE_DROP_IDLE_EN
    logic [7:0] drop_cnt_r;
    assign store_s  = push_s && (in_bus.in_code != IDLE_CODE);
    assign drop_cnt = drop_cnt_r;

    // Saturating count of handshaken-but-discarded sink codes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_r <= 8'd0;
        end else if (push_s && (in_bus.in_code == IDLE_CODE) && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end
`else
    assign store_s = push_s;
`endif

    lu_code_fifo #(
        .DEPTH (DEPTH),
        .W     (LU_ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (store_s),
        .pop   (pop_s),
        .din   (in_bus.in_code),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (fifo_level)
    );

    // Next-state logic; flush counting starts only once DRAIN has emptied the FIFO.
    always_comb begin
        state_s     = state_r;
        flush_cnt_s = {FW{1'b0}};
        done_s      = 1'b0;
        case (state_r)
            ISS_IDLE: begin
                if (start) state_s = ISS_RUN;
                else       state_s = ISS_IDLE;
            end
            ISS_RUN: begin
                if (stop) state_s = ISS_DRAIN;
                else      state_s = ISS_RUN;
            end
            ISS_DRAIN: begin
                if (!empty_s) begin
                    flush_cnt_s = {FW{1'b0}};
                end else if (flush_cnt_r == FW'(FLUSH_CYCLES - 1)) begin
                    done_s  = 1'b1;
                    state_s = ISS_IDLE;
                end else begin
                    flush_cnt_s = flush_cnt_r + FW'(1);
                end
            end
            default: state_s = ISS_IDLE;
        endcase
    end

    // State, output code register and issued counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ISS_IDLE;
            flush_cnt_r  <= {FW{1'b0}};
            done_r       <= 1'b0;
            icode_r      <= IDLE_CODE;
            icode_live_r <= 1'b0;
            issued_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            flush_cnt_r <= flush_cnt_s;
            done_r      <= done_s;
            if (pop_s) begin
                icode_r      <= head_s;
                icode_live_r <= 1'b1;
            end else begin
                icode_r      <= IDLE_CODE;
                icode_live_r <= 1'b0;
            end
            if ((state_r == ISS_IDLE) && start) begin
                issued_cnt_r <= {CNT_W{1'b0}};
            end else if (pop_s && (issued_cnt_r != {CNT_W{1'b1}})) begin
                issued_cnt_r <= issued_cnt_r + CNT_W'(1);
            end else begin
                issued_cnt_r <= issued_cnt_r;
            end
        end
    end

    assign icode      = icode_r;
    assign icode_live = icode_live_r;
    assign done       = done_r;
    assign busy       = (state_r != ISS_IDLE);
    assign issued_cnt = issued_cnt_r;

endmodule
